ddr2_local_arbiter: RTL and testbench

Two-port arbiter and burst sequencer in front of the `ddr2_controller_phy` local interface. It shares the single DDR2 local port between a write requester (camera frame writer) and a read requester (Ethernet frame reader). It runs each granted request as one local burst and tracks outstanding read beats so read data is never over-committed. It sits in the `phy_clk` domain between the frame FIFOs and the DDR2 controller.

---
 rtl/ddr2_arb_pkg.sv | 16 +
 rtl/ddr2_rd_tracker.sv | 51 +++++
 rtl/ddr2_local_arbiter.sv | 166 ++++++++++++++++
 tb/tb_ddr2_local_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr2_arb_pkg.sv
// Shared types and defaults for the DDR2 local-port arbiter and its read tracker.
package ddr2_arb_pkg;

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_e;
  typedef enum logic {PORT_WR, PORT_RD} port_e;

  localparam int unsigned DEF_ADDR_W          = 25;
  localparam int unsigned DEF_DATA_W          = 32;
  localparam int unsigned DEF_SIZE_W          = 3;
  localparam int unsigned DEF_MAX_BURST       = 4;
  localparam int unsigned DEF_MAX_OUTSTANDING = 16;

  localparam int unsigned ERR_LEN      = 0;
  localparam int unsigned ERR_SPURIOUS = 1;

endpackage

// File: rtl/ddr2_rd_tracker.sv
// Read-credit tracker: counts read beats in flight so the arbiter never
// commits more returning data than the downstream path can absorb.
module ddr2_rd_tracker
  import ddr2_arb_pkg::*;
#(
  parameter int unsigned SIZE_W          = DEF_SIZE_W,
  parameter int unsigned MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
  parameter int unsigned CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              issue_i,
  input  logic [SIZE_W-1:0] issue_len_i,
  input  logic [SIZE_W-1:0] check_len_i,
  input  logic              rvalid_i,
  output logic              can_issue_o,
  output logic              spurious_o
);

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [CNT_W:0]   wide_t;

  cnt_t  count_q, count_d;
  logic  quiet_q, quiet_d;
  logic  beat_counted;
  wide_t projected;

  // Beats from reads issued before a reset may still come back; they are
  // neither counted nor flagged until the first new read command goes out.
  always_comb begin
    projected    = wide_t'(count_q) + wide_t'(check_len_i);
    can_issue_o  = (projected <= wide_t'(MAX_OUTSTANDING));
    spurious_o   = rvalid_i && !quiet_q && (count_q == '0);
    beat_counted = rvalid_i && !quiet_q && (count_q != '0);
    quiet_d      = quiet_q && !issue_i;
    count_d      = count_q;
    if (issue_i) count_d = count_d + cnt_t'(issue_len_i);
    if (beat_counted) count_d = count_d - cnt_t'(1);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
      quiet_q <= 1'b1;
    end else begin
      count_q <= count_d;
      quiet_q <= quiet_d;
    end
  end

endmodule

// File: rtl/ddr2_local_arbiter.sv
// Shares the DDR2 local port between a write requester and a read requester,
// running each grant as one local burst with read-credit flow control.
module ddr2_local_arbiter
  import ddr2_arb_pkg::*;
#(
  parameter int unsigned ADDR_W          = DEF_ADDR_W,
  parameter int unsigned DATA_W          = DEF_DATA_W,
  parameter int unsigned SIZE_W          = DEF_SIZE_W,
  parameter int unsigned MAX_BURST       = DEF_MAX_BURST,
  parameter int unsigned MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
  input  logic                phy_clk,
  input  logic                reset_phy_clk,
  input  logic                local_init_done,
  input  logic                local_ready,
  input  logic [DATA_W-1:0]   local_rdata,
  input  logic                local_rdata_valid,
  output logic [ADDR_W-1:0]   local_address,
  output logic [SIZE_W-1:0]   local_size,
  output logic                local_burstbegin,
  output logic                local_write_req,
  output logic                local_read_req,
  output logic [DATA_W-1:0]   local_wdata,
  output logic [DATA_W/8-1:0] local_be,
  input  logic                wr_req,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [SIZE_W-1:0]   wr_len,
  output logic                wr_grant,
  input  logic [DATA_W-1:0]   wr_data,
  output logic                wr_data_ack,
  input  logic                rd_req,
  input  logic [ADDR_W-1:0]   rd_addr,
  input  logic [SIZE_W-1:0]   rd_len,
  output logic                rd_grant,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_data_valid,
  output logic [1:0]          err
);

  typedef logic [SIZE_W-1:0] len_t;
  localparam len_t MAX_LEN = len_t'(MAX_BURST);

  state_e              state_q, state_d;
  port_e               last_q, last_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  len_t                len_q, len_d, beat_q, beat_d;
  logic                wr_grant_q, wr_grant_d, rd_grant_q, rd_grant_d;
  logic [1:0]          err_q, err_d;
  logic [DATA_W-1:0]   rd_data_q;
  logic                rd_valid_q;

  logic rd_can_issue, spurious, rd_issue;
  logic arb_en, wr_elig, rd_elig, pick_wr, pick_rd;
  len_t sel_len;
  logic sel_legal;

  ddr2_rd_tracker #(
    .SIZE_W          (SIZE_W),
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) u_rd_tracker (
    .clk_i       (phy_clk),
    .reset_i     (reset_phy_clk),
    .issue_i     (rd_issue),
    .issue_len_i (len_q),
    .check_len_i (rd_len),
    .rvalid_i    (local_rdata_valid),
    .can_issue_o (rd_can_issue),
    .spurious_o  (spurious)
  );

  // Arbitration is held off during the grant cycle so a requester that only
  // drops req after seeing its grant is not granted twice.
  assign arb_en    = (state_q == IDLE) && local_init_done && !wr_grant_q && !rd_grant_q;
  assign wr_elig   = wr_req;
  assign rd_elig   = rd_req && rd_can_issue;
  assign pick_wr   = wr_elig && (!rd_elig || (last_q == PORT_RD));
  assign pick_rd   = rd_elig && !pick_wr;
  assign sel_len   = pick_wr ? wr_len : rd_len;
  assign sel_legal = (sel_len != '0) && (sel_len <= MAX_LEN);
  assign rd_issue  = (state_q == READ) && local_ready;

  always_comb begin
    state_d          = state_q;
    last_d           = last_q;
    addr_d           = addr_q;
    len_d            = len_q;
    beat_d           = beat_q;
    wr_grant_d       = 1'b0;
    rd_grant_d       = 1'b0;
    err_d            = err_q;
    local_write_req  = 1'b0;
    local_read_req   = 1'b0;
    local_burstbegin = 1'b0;
    if (spurious) err_d[ERR_SPURIOUS] = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (arb_en && (pick_wr || pick_rd)) begin
          addr_d     = pick_wr ? wr_addr : rd_addr;
          len_d      = sel_len;
          last_d     = pick_wr ? PORT_WR : PORT_RD;
          wr_grant_d = pick_wr;
          rd_grant_d = pick_rd;
          beat_d     = '0;
          if (sel_legal) state_d = pick_wr ? WRITE : READ;
          else err_d[ERR_LEN] = 1'b1;
        end
      end
      WRITE: begin
        local_write_req  = 1'b1;
        local_burstbegin = (beat_q == '0);
        if (local_ready) begin
          if (beat_q == len_q - len_t'(1)) begin
            beat_d  = '0;
            state_d = IDLE;
          end else begin
            beat_d = beat_q + len_t'(1);
          end
        end
      end
      READ: begin
        local_read_req   = 1'b1;
        local_burstbegin = 1'b1;
        if (local_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge phy_clk) begin
    if (reset_phy_clk) begin
      state_q    <= IDLE;
      last_q     <= PORT_RD;
      addr_q     <= '0;
      len_q      <= '0;
      beat_q     <= '0;
      wr_grant_q <= 1'b0;
      rd_grant_q <= 1'b0;
      err_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      beat_q     <= beat_d;
      wr_grant_q <= wr_grant_d;
      rd_grant_q <= rd_grant_d;
      err_q      <= err_d;
      rd_data_q  <= local_rdata;
      rd_valid_q <= local_rdata_valid;
    end
  end

  assign local_address = addr_q;
  assign local_size    = len_q;
  assign local_wdata   = (state_q == WRITE) ? wr_data : '0;
  assign local_be      = '1;
  assign wr_data_ack   = local_write_req & local_ready;
  assign wr_grant      = wr_grant_q;
  assign rd_grant      = rd_grant_q;
  assign rd_data       = rd_data_q;
  assign rd_data_valid = rd_valid_q;
  assign err           = err_q;

endmodule

// File: tb/tb_ddr2_local_arbiter.sv
// Directed self-checking bench for ddr2_local_arbiter with hand-computed expectations.
module tb_ddr2_local_arbiter;

  logic        phy_clk = 1'b0;
  logic        reset_phy_clk;
  logic        local_init_done, local_ready;
  logic [31:0] local_rdata;
  logic        local_rdata_valid;
  logic [24:0] local_address;
  logic [2:0]  local_size;
  logic        local_burstbegin, local_write_req, local_read_req;
  logic [31:0] local_wdata;
  logic [3:0]  local_be;
  logic        wr_req, rd_req, wr_grant, rd_grant, wr_data_ack, rd_data_valid;
  logic [24:0] wr_addr, rd_addr;
  logic [2:0]  wr_len, rd_len;
  logic [31:0] wr_data, rd_data;
  logic [1:0]  err;

  int checks   = 0;
  int failures = 0;

  ddr2_local_arbiter dut (
    .phy_clk           (phy_clk),
    .reset_phy_clk     (reset_phy_clk),
    .local_init_done   (local_init_done),
    .local_ready       (local_ready),
    .local_rdata       (local_rdata),
    .local_rdata_valid (local_rdata_valid),
    .local_address     (local_address),
    .local_size        (local_size),
    .local_burstbegin  (local_burstbegin),
    .local_write_req   (local_write_req),
    .local_read_req    (local_read_req),
    .local_wdata       (local_wdata),
    .local_be          (local_be),
    .wr_req            (wr_req),
    .wr_addr           (wr_addr),
    .wr_len            (wr_len),
    .wr_grant          (wr_grant),
    .wr_data           (wr_data),
    .wr_data_ack       (wr_data_ack),
    .rd_req            (rd_req),
    .rd_addr           (rd_addr),
    .rd_len            (rd_len),
    .rd_grant          (rd_grant),
    .rd_data           (rd_data),
    .rd_data_valid     (rd_data_valid),
    .err               (err)
  );

  always #5 phy_clk = ~phy_clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic wReq, input logic [24:0] wAddr, input logic [2:0] wLen,
                               input logic rReq, input logic [24:0] rAddr, input logic [2:0] rLen);
    wr_req  = wReq;
    wr_addr = wAddr;
    wr_len  = wLen;
    rd_req  = rReq;
    rd_addr = rAddr;
    rd_len  = rLen;
  endtask

  task automatic nextCycle();
    @(posedge phy_clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic waitGrant(input bit wantWr, input int budget, input string tag);
    int  n    = 0;
    bit  seen = 1'b0;
    while (!seen && n < budget) begin
      nextCycle();
      settle();
      seen = wantWr ? wr_grant : rd_grant;
      n++;
    end
    checkOutput(tag, seen, 1);
  endtask

  initial begin
    int  ackCount;
    int  beat;
    int  nGrants;
    byte seq [6];
    int  readyPat [7];

    readyPat = '{0, 1, 0, 1, 1, 0, 1};
    reset_phy_clk     = 1'b1;
    local_init_done   = 1'b1;
    local_ready       = 1'b1;
    local_rdata       = '0;
    local_rdata_valid = 1'b0;
    wr_data           = '0;
    applyStimulus(0, 0, 0, 0, 0, 0);

    repeat (3) nextCycle();
    settle();
    checkOutput("reset_write_req", local_write_req, 0);
    checkOutput("reset_read_req", local_read_req, 0);
    checkOutput("reset_burstbegin", local_burstbegin, 0);
    checkOutput("reset_be", local_be, 4'hF);
    checkOutput("reset_err", err, 0);
    checkOutput("reset_grants", {wr_grant, rd_grant}, 0);
    checkOutput("reset_rd_valid", rd_data_valid, 0);
    checkOutput("reset_address", local_address, 0);
    checkOutput("reset_wdata", local_wdata, 0);

    // Single write, ready always high
    nextCycle();
    reset_phy_clk = 1'b0;
    applyStimulus(1, 25'h100, 4, 0, 0, 0);
    wr_data = 32'hA0;
    settle();
    checkOutput("t1_no_grant_yet", wr_grant, 0);
    nextCycle();
    settle();
    checkOutput("t1_grant", wr_grant, 1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    ackCount = 0;
    for (int b = 0; b < 4; b++) begin
      if (b > 0) nextCycle();
      wr_data = 32'hA0 + b;
      settle();
      checkOutput($sformatf("t1_write_req_b%0d", b), local_write_req, 1);
      checkOutput($sformatf("t1_burstbegin_b%0d", b), local_burstbegin, (b == 0));
      checkOutput($sformatf("t1_address_b%0d", b), local_address, 25'h100);
      checkOutput($sformatf("t1_size_b%0d", b), local_size, 4);
      checkOutput($sformatf("t1_wdata_b%0d", b), local_wdata, 32'hA0 + b);
      ackCount += int'(wr_data_ack);
    end
    nextCycle();
    settle();
    checkOutput("t1_idle_write_req", local_write_req, 0);
    checkOutput("t1_idle_ack", wr_data_ack, 0);
    checkOutput("t1_ack_count", ackCount, 4);

    // Single write with local_ready stalls
    applyStimulus(1, 25'h200, 4, 0, 0, 0);
    wr_data = 32'hB0;
    nextCycle();
    settle();
    checkOutput("t2_grant", wr_grant, 1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    ackCount = 0;
    beat     = 0;
    for (int c = 0; c < 7; c++) begin
      if (c > 0) nextCycle();
      local_ready = readyPat[c][0];
      wr_data     = 32'hB0 + beat;
      settle();
      checkOutput($sformatf("t2_write_req_c%0d", c), local_write_req, 1);
      checkOutput($sformatf("t2_address_c%0d", c), local_address, 25'h200);
      checkOutput($sformatf("t2_burstbegin_c%0d", c), local_burstbegin, (beat == 0));
      checkOutput($sformatf("t2_wdata_c%0d", c), local_wdata, 32'hB0 + beat);
      checkOutput($sformatf("t2_ack_c%0d", c), wr_data_ack, readyPat[c]);
      ackCount += int'(wr_data_ack);
      beat += readyPat[c];
    end
    nextCycle();
    local_ready = 1'b1;
    settle();
    checkOutput("t2_idle_write_req", local_write_req, 0);
    checkOutput("t2_ack_count", ackCount, 4);

    // Tie arbitration from reset: W, R, W, R ...
    reset_phy_clk = 1'b1;
    applyStimulus(1, 25'h300, 2, 1, 25'h400, 1);
    repeat (2) nextCycle();
    reset_phy_clk = 1'b0;
    nGrants = 0;
    for (int c = 0; c < 60 && nGrants < 6; c++) begin
      nextCycle();
      settle();
      if (wr_grant) begin
        seq[nGrants] = "W";
        nGrants++;
      end else if (rd_grant) begin
        seq[nGrants] = "R";
        nGrants++;
      end
    end
    checkOutput("t3_grant_count", nGrants, 6);
    for (int i = 0; i < 6; i++)
      checkOutput($sformatf("t3_grant_order_%0d", i), seq[i], (i % 2 == 0) ? 8'h57 : 8'h52);

    // Credit limit: four len-4 reads fill the 16-beat budget
    applyStimulus(0, 0, 0, 0, 0, 0);
    reset_phy_clk = 1'b1;
    repeat (2) nextCycle();
    reset_phy_clk = 1'b0;
    for (int r = 0; r < 4; r++) begin
      applyStimulus(0, 0, 0, 1, 25'h1000 + 25'(r * 4), 4);
      waitGrant(1'b0, 10, $sformatf("t4_read_grant_%0d", r));
      checkOutput($sformatf("t4_read_req_%0d", r), local_read_req, 1);
    end
    applyStimulus(0, 0, 0, 1, 25'h2000, 4);
    for (int c = 0; c < 3; c++) begin
      nextCycle();
      settle();
      checkOutput($sformatf("t4_blocked_a%0d", c), rd_grant, 0);
    end
    applyStimulus(1, 25'h500, 1, 1, 25'h2000, 4);
    waitGrant(1'b1, 10, "t4_write_granted");
    checkOutput("t4_no_rd_with_wr", rd_grant, 0);
    applyStimulus(0, 0, 0, 1, 25'h2000, 4);
    for (int c = 0; c < 3; c++) begin
      nextCycle();
      settle();
      checkOutput($sformatf("t4_blocked_b%0d", c), rd_grant, 0);
    end
    nextCycle();
    local_rdata_valid = 1'b1;
    local_rdata       = 32'hD0;
    settle();
    nextCycle();
    local_rdata_valid = 1'b0;
    settle();
    checkOutput("t4_rd_data_first", rd_data, 32'hD0);
    checkOutput("t4_rd_valid_first", rd_data_valid, 1);
    for (int c = 0; c < 3; c++) begin
      nextCycle();
      settle();
      checkOutput($sformatf("t4_blocked_c%0d", c), rd_grant, 0);
    end
    for (int i = 0; i < 3; i++) begin
      nextCycle();
      local_rdata_valid = 1'b1;
      local_rdata       = 32'hD1 + i;
      settle();
      if (i > 0) checkOutput($sformatf("t4_rd_data_%0d", i), rd_data, 32'hD1 + i - 1);
    end
    nextCycle();
    local_rdata_valid = 1'b0;
    settle();
    checkOutput("t4_rd_data_last", rd_data, 32'hD3);
    waitGrant(1'b0, 10, "t4_read_unblocked");
    applyStimulus(0, 0, 0, 0, 0, 0);

    // Return all 16 outstanding beats, then one spurious beat
    for (int i = 0; i < 16; i++) begin
      nextCycle();
      local_rdata_valid = 1'b1;
      local_rdata       = 32'hE00 + i;
      settle();
      if (i > 0) checkOutput($sformatf("t5_rd_data_%0d", i), rd_data, 32'hE00 + i - 1);
    end
    nextCycle();
    local_rdata_valid = 1'b0;
    settle();
    checkOutput("t5_rd_data_last", rd_data, 32'hE0F);
    checkOutput("t5_err_before", err, 2'b00);
    nextCycle();
    local_rdata_valid = 1'b1;
    local_rdata       = 32'hBAD;
    settle();
    nextCycle();
    local_rdata_valid = 1'b0;
    settle();
    checkOutput("t5_err_spurious", err, 2'b10);
    checkOutput("t5_spurious_forwarded", rd_data, 32'hBAD);
    repeat (3) nextCycle();
    settle();
    checkOutput("t5_err_sticky", err, 2'b10);

    // Zero-length request: granted, dropped, err[0]
    applyStimulus(1, 25'h600, 0, 0, 0, 0);
    nextCycle();
    settle();
    checkOutput("t6_len0_grant", wr_grant, 1);
    checkOutput("t6_len0_no_write", local_write_req, 0);
    checkOutput("t6_len0_err", err, 2'b11);
    applyStimulus(0, 0, 0, 0, 0, 0);
    nextCycle();
    settle();
    checkOutput("t6_len0_still_idle", {local_write_req, local_read_req, wr_grant}, 0);

    // Reset on the second beat of a write
    applyStimulus(1, 25'h700, 4, 0, 0, 0);
    wr_data = 32'hC0;
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0);
    settle();
    checkOutput("t7_beat0", local_write_req, 1);
    nextCycle();
    wr_data = 32'hC1;
    settle();
    checkOutput("t7_beat1_bb", {local_write_req, local_burstbegin}, 2'b10);
    reset_phy_clk = 1'b1;
    nextCycle();
    settle();
    checkOutput("t7_reset_reqs", {local_write_req, local_read_req, local_burstbegin, wr_data_ack}, 0);
    checkOutput("t7_reset_err", err, 0);
    nextCycle();
    reset_phy_clk     = 1'b0;
    local_rdata_valid = 1'b1;
    local_rdata       = 32'hF00D;
    settle();
    nextCycle();
    local_rdata_valid = 1'b0;
    settle();
    checkOutput("t7_stale_valid", rd_data_valid, 1);
    checkOutput("t7_stale_data", rd_data, 32'hF00D);
    checkOutput("t7_stale_no_err", err, 0);
    checkOutput("t7_no_more_beats", local_write_req, 0);

    // init_done low blocks all grants
    local_init_done = 1'b0;
    applyStimulus(1, 25'h800, 2, 1, 25'h900, 1);
    for (int c = 0; c < 5; c++) begin
      nextCycle();
      settle();
      checkOutput($sformatf("t8_no_grant_%0d", c), {wr_grant, rd_grant}, 0);
    end
    local_init_done = 1'b1;
    waitGrant(1'b1, 5, "t8_grant_after_init");
    applyStimulus(0, 0, 0, 0, 0, 0);
    repeat (4) nextCycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
